mul_share_ctrl: RTL
===================

# mul_share_ctrl

Sequencing and arbitration controller for the shared shift-add multiplier datapath (A/B operand registers, product register P, adder). Two requesters share one datapath; the block grants one requester at a time and drives the datapath strobes clr, load_ab, en_add, load_p, shf_p and shf_b for a WIDTH-iteration multiply. It returns a one-cycle done pulse to the granted requester. It replaces the free-running, run-once sequencer with a request/grant/done interface.

## Interface
- WIDTH, default 4: operand width in bits. Also the number of add/shift iterations. Legal range 2–16.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- req  in  2  per-requester request; held high until that requester's done pulse.
- b_lsb  in  1  current LSB of the datapath B register.
- gnt  out  2  one-hot grant, held from CLR through DONE inclusive.
- sel  out  1  operand/result mux select (index of granted requester). Holds its last value while idle.
- done  out  2  one-cycle pulse to the granted requester in the DONE state.
- busy  out  1  high in every state except IDLE.
- clr, load_ab, en_add, load_p, shf_p, shf_b  out  1 each  datapath strobes.

## Operation
- States:
  - IDLE
  - CLR
  - LOAD_AB
  - EN_ADD
  - LOAD_P
  - SHF_P
  - SHF_B
  - DONE
- All outputs are Moore-decoded from the state register plus the registered grant (gnt/sel).
- Strobes are one-hot per state: CLR→clr, LOAD_AB→load_ab, EN_ADD→en_add, LOAD_P→load_p, SHF_P→shf_p, SHF_B→shf_b. All strobes are 0 in IDLE and DONE.
- IDLE:
  - If any req bit is high, arbitrate, register gnt/sel, and go to CLR.
  - Otherwise stay in IDLE.
- Arbitration is round-robin using a last-served pointer (lsp):
  - A single request wins outright.
  - If both request, the one not equal to lsp wins.
  - lsp updates to the winner when leaving IDLE.
- Transitions: CLR→LOAD_AB→EN_ADD→LOAD_P→SHF_P.
- Leaving SHF_P:
  - If iter == WIDTH-1, go to DONE.
  - Otherwise go to SHF_B→EN_ADD. iter increments when leaving SHF_P.
- The last iteration has no SHF_B.
- iter is $clog2(WIDTH) bits. It clears to 0 in CLR.
- DONE: pulse done[sel], then go to IDLE. There is always at least one IDLE cycle between operations.
- If req drops mid-operation, the operation still completes and done still pulses.
- New req changes during an operation are ignored until IDLE.
- A requester must deassert req in the cycle after its done pulse. If it does not, it is treated as a new request, subject to round-robin.

## Timing
- Reset values:
  - State IDLE.
  - gnt=00, sel=0, done=00, busy=0.
  - All strobes 0, iter=0.
  - lsp=1, so requester 0 wins the first tie.
- Reset asserted mid-operation returns the block to IDLE immediately (asynchronously) with the reset values above. No done pulse is issued, and the aborted requester must re-request.
- Cycle numbering: the cycle in which req is first sampled high in IDLE is t. CLR is at t+1.
- Non-skip operation: LOAD_AB at t+2, first EN_ADD at t+3, DONE at t+4·WIDTH+2.
  - For WIDTH=4, DONE is at t+18.
  - The sequence contains WIDTH en_add, WIDTH load_p, WIDTH shf_p and WIDTH-1 shf_b strobes.
- Earliest next grant is at the IDLE cycle following DONE. The next CLR is at DONE+2.

## Configuration
- Macro MUL_SKIP_ZERO_EN.
- When defined:
  - In EN_ADD, if b_lsb==0 the next state is SHF_P, skipping LOAD_P. en_add is still asserted but has no effect on P.
  - Each zero bit among the low WIDTH bits of B saves one cycle.
  - The last iteration's bit counts too.
- When undefined:
  - b_lsb is ignored and EN_ADD always goes to LOAD_P.
  - Latency is fixed at 4·WIDTH+2 cycles from request to DONE.

## Test plan
- Reset, then req=01, WIDTH=4, macro off → gnt=01 from t+1 to t+18, done[0] pulse at t+18, strobe counts 4/4/4/3, busy low at t+19.
- Both req=11 held continuously → grants alternate: requester 0, then 1, then 0. Each grant is separated by one IDLE cycle and each done pulse goes only to the granted bit.
- req[1] drops at t+8 while granted → sequence still completes and done[1] pulses at t+18.
- reset pulsed at t+10 → all outputs 0 immediately. A new req=10 then completes normally with sel=1.
- MUL_SKIP_ZERO_EN defined, b_lsb held 0 → 0 load_p strobes and DONE at t+14. With b_lsb=1 → DONE at t+18.
- Requester 0 holds req after done → one IDLE cycle, then requester 0 is re-granted only if req[1]=0. Otherwise requester 1 is granted.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin request/grant sequencer for the shared shift-add multiplier
// Optional feature macro: MUL_SKIP_ZERO_EN (skip LOAD_P when the B register LSB is 0).
module mul_share_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       b_lsb_i,
    output logic [1:0] gnt_o,
    output logic       sel_o,
    output logic [1:0] done_o,
    output logic       busy_o,
    output logic       clr_o,
    output logic       load_ab_o,
    output logic       en_add_o,
    output logic       load_p_o,
    output logic       shf_p_o,
    output logic       shf_b_o
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD_AB, S_EN_ADD, S_LOAD_P, S_SHF_P, S_SHF_B, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          lsp_q, lsp_d;
    logic          sel_q, sel_d;
    logic          win;

    // On a tie the requester that was not served last wins.
    assign win = (req_i == 2'b11) ? ~lsp_q : req_i[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            lsp_q   <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            lsp_q   <= lsp_d;
            sel_q   <= sel_d;
        end
    end

`ifndef MUL_SKIP_ZERO_EN
    logic unused_b_lsb;
    assign unused_b_lsb = b_lsb_i;
`endif

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        lsp_d   = lsp_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    state_d = S_CLR;
                    sel_d   = win;
                    lsp_d   = win;
                end
            end
            S_CLR: begin
                iter_d  = '0;
                state_d = S_LOAD_AB;
            end
            S_LOAD_AB: state_d = S_EN_ADD;
            S_EN_ADD: begin
`ifdef MUL_SKIP_ZERO_EN
                state_d = b_lsb_i ? S_LOAD_P : S_SHF_P;
`else
                state_d = S_LOAD_P;
`endif
            end
            S_LOAD_P: state_d = S_SHF_P;
            S_SHF_P: begin
                iter_d  = iter_q + 1'b1;
                state_d = (iter_q == ITER_LAST) ? S_DONE : S_SHF_B;
            end
            S_SHF_B: state_d = S_EN_ADD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q != S_IDLE);
        sel_o     = sel_q;
        gnt_o     = busy_o ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
        done_o    = (state_q == S_DONE) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
        clr_o     = (state_q == S_CLR);
        load_ab_o = (state_q == S_LOAD_AB);
        en_add_o  = (state_q == S_EN_ADD);
        load_p_o  = (state_q == S_LOAD_P);
        shf_p_o   = (state_q == S_SHF_P);
        shf_b_o   = (state_q == S_SHF_B);
    end

endmodule
